alu_select_pipe: RTL and testbench

- Parametrised successor to the fixed 8-bit mux/adder/subtractor datapath.
- Registered, 2-stage arithmetic select pipeline:
  - per transaction, an opcode picks one of four results: pass, add, subtract, or accumulate;
  - optional saturation; result flags;
  - valid/ready handshake on both sides with full-throughput backpressure.
- Keeps per-operand monitor outputs so top-level benches observe internal operands and the accumulator directly.

---
 rtl/alu_select_pipe_if.sv | 37 +++
 rtl/alu_select_pipe.sv | 182 ++++++++++++++++++
 tb/tb_alu_select_pipe.sv | 337 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_select_pipe_if.sv
// ----------------------------------------------------------------------------
// alu_select_pipe_if
//   Handshake bundle for alu_select_pipe.
//   Input side : in_valid/in_ready with operands a, b, c, opcode op and the
//                handshake-independent accumulator clear acc_clr.
//   Output side: out_valid/out_ready with result out and flags
//                out_carry, out_sat, out_zero.
//   master : the producer/consumer around the pipe (drives operands, out_ready)
//   slave  : the pipe itself
// ----------------------------------------------------------------------------
interface alu_select_pipe_if #(
   parameter int WIDTH = 8
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic [WIDTH-1:0] c;
   logic [1:0]       op;
   logic             acc_clr;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out;
   logic             out_carry;
   logic             out_sat;
   logic             out_zero;

   modport master (
      output in_valid, a, b, c, op, acc_clr, out_ready,
      input  in_ready, out_valid, out, out_carry, out_sat, out_zero
   );

   modport slave (
      input  in_valid, a, b, c, op, acc_clr, out_ready,
      output in_ready, out_valid, out, out_carry, out_sat, out_zero
   );
endinterface

// File: rtl/alu_select_pipe.sv
// ----------------------------------------------------------------------------
// alu_select_pipe
//   Two-stage registered arithmetic select pipeline. Stage 1 captures the
//   operand bundle; stage 2 computes PASS / ADD / SUB / ACC at WIDTH+1 bits,
//   optionally saturates, and registers the result with its flags. Both sides
//   use valid/ready with full throughput under backpressure.
//
// Ports
//   clk           rising-edge clock
//   reset         synchronous, active-high; clears all state
//   bus           alu_select_pipe_if.slave (operands in, result out)
//   s1_a_monitor  stage-1 registered A
//   s1_b_monitor  stage-1 registered B
//   s1_c_monitor  stage-1 registered C
//   acc_monitor   accumulator register
//   occupancy     number of valid stages (0..2)
// ----------------------------------------------------------------------------
module alu_select_pipe #(
   parameter int WIDTH  = 8,
   parameter bit SAT_EN = 1'b0
) (
   input  logic                 clk,
   input  logic                 reset,
   alu_select_pipe_if.slave     bus,
   output logic [WIDTH-1:0]     s1_a_monitor,
   output logic [WIDTH-1:0]     s1_b_monitor,
   output logic [WIDTH-1:0]     s1_c_monitor,
   output logic [WIDTH-1:0]     acc_monitor,
   output logic [1:0]           occupancy
);

   typedef enum logic [1:0] {
      OP_PASS = 2'd0,
      OP_ADD  = 2'd1,
      OP_SUB  = 2'd2,
      OP_ACC  = 2'd3
   } op_e;

   // Stage 1: operand bundle
   logic             s1_valid_q, s1_valid_d;
   logic [WIDTH-1:0] s1_a_q, s1_a_d;
   logic [WIDTH-1:0] s1_b_q, s1_b_d;
   logic [WIDTH-1:0] s1_c_q, s1_c_d;
   op_e              s1_op_q, s1_op_d;

   // Stage 2: registered result and flags
   logic             out_valid_q, out_valid_d;
   logic [WIDTH-1:0] out_q, out_d;
   logic             carry_q, carry_d;
   logic             sat_q, sat_d;
   logic             zero_q, zero_d;

   logic [WIDTH-1:0] acc_q, acc_d;

   logic             s1_adv;
   logic             in_fire;
   logic [WIDTH:0]   sum_w;
   logic             res_carry;
   logic             res_sat;
   logic [WIDTH-1:0] res_val;

   // Stage 1 moves on whenever stage 2 is empty or is being drained this cycle.
   assign s1_adv       = s1_valid_q && (!out_valid_q || bus.out_ready);
   assign bus.in_ready = !reset && (!s1_valid_q || s1_adv);
   assign in_fire      = bus.in_valid && bus.in_ready;

   always_comb begin : result_calc
      // NOTE: every combinational output gets a default before any branch, so
      // no path leaves a signal unassigned and no latch is inferred.
      sum_w     = {1'b0, s1_a_q};
      res_carry = 1'b0;
      case (s1_op_q)
         OP_ADD: begin
            sum_w     = {1'b0, s1_a_q} + {1'b0, s1_b_q};
            res_carry = sum_w[WIDTH];
         end
         OP_SUB: begin
            sum_w     = {1'b0, s1_a_q} - {1'b0, s1_c_q};
            res_carry = (s1_a_q < s1_c_q);
         end
         OP_ACC: begin
            sum_w     = {1'b0, acc_q} + {1'b0, s1_a_q};
            res_carry = sum_w[WIDTH];
         end
         default: ;
      endcase

      res_val = sum_w[WIDTH-1:0];
      res_sat = 1'b0;
      // Overflow clamps high, underflow (SUB borrow) clamps to zero.
      if (SAT_EN && res_carry) begin
         res_sat = 1'b1;
         res_val = (s1_op_q == OP_SUB) ? '0 : '1;
      end
   end

   always_comb begin : next_state
      s1_valid_d  = s1_valid_q;
      s1_a_d      = s1_a_q;
      s1_b_d      = s1_b_q;
      s1_c_d      = s1_c_q;
      s1_op_d     = s1_op_q;
      out_valid_d = out_valid_q;
      out_d       = out_q;
      carry_d     = carry_q;
      sat_d       = sat_q;
      zero_d      = zero_q;
      acc_d       = acc_q;

      if (in_fire) begin
         s1_valid_d = 1'b1;
         s1_a_d     = bus.a;
         s1_b_d     = bus.b;
         s1_c_d     = bus.c;
         s1_op_d    = op_e'(bus.op);
      end else if (s1_adv) begin
         s1_valid_d = 1'b0;
      end

      if (s1_adv) begin
         out_valid_d = 1'b1;
         out_d       = res_val;
         carry_d     = res_carry;
         sat_d       = res_sat;
         zero_d      = (res_val == '0);
      end else if (bus.out_ready) begin
         out_valid_d = 1'b0;
      end

      // A same-cycle ACC advance still used the old acc for its result above;
      // the clear only decides what the register holds next.
      if (bus.acc_clr) begin
         acc_d = '0;
      end else if (s1_adv && (s1_op_q == OP_ACC)) begin
         acc_d = res_val;
      end
   end

   always_ff @(posedge clk) begin
      // NOTE: datapath registers are reset too, not just valids, because
      // out, the flags and the monitors are all observable as zero in reset.
      if (reset) begin
         s1_valid_q  <= 1'b0;
         s1_a_q      <= '0;
         s1_b_q      <= '0;
         s1_c_q      <= '0;
         s1_op_q     <= OP_PASS;
         out_valid_q <= 1'b0;
         out_q       <= '0;
         carry_q     <= 1'b0;
         sat_q       <= 1'b0;
         zero_q      <= 1'b0;
         acc_q       <= '0;
      end else begin
         // NOTE: non-blocking assignments so every flop samples pre-edge values.
         s1_valid_q  <= s1_valid_d;
         s1_a_q      <= s1_a_d;
         s1_b_q      <= s1_b_d;
         s1_c_q      <= s1_c_d;
         s1_op_q     <= s1_op_d;
         out_valid_q <= out_valid_d;
         out_q       <= out_d;
         carry_q     <= carry_d;
         sat_q       <= sat_d;
         zero_q      <= zero_d;
         acc_q       <= acc_d;
      end
   end

   assign bus.out_valid = out_valid_q;
   assign bus.out       = out_q;
   assign bus.out_carry = carry_q;
   assign bus.out_sat   = sat_q;
   assign bus.out_zero  = zero_q;

   assign s1_a_monitor  = s1_a_q;
   assign s1_b_monitor  = s1_b_q;
   assign s1_c_monitor  = s1_c_q;
   assign acc_monitor   = acc_q;
   assign occupancy     = {1'b0, s1_valid_q} + {1'b0, out_valid_q};

endmodule

// File: tb/tb_alu_select_pipe.sv
// ----------------------------------------------------------------------------
// tb_alu_select_pipe
//   Drives a wrapping (SAT_EN=0) and a saturating (SAT_EN=1) instance with the
//   same stimulus and compares both against a transaction-level model: a queue
//   of accepted bundles, where the oldest one becomes the visible result one
//   edge after it was accepted, and the accumulator follows ACC results in
//   order with acc_clr taking effect after any same-edge ACC result.
// ----------------------------------------------------------------------------
module tb_alu_select_pipe;
   localparam int W   = 8;
   localparam int TOP = (1 << W) - 1;

   typedef struct {
      int op;
      int a;
      int b;
      int c;
      int age;
      bit shown;
   } txn_t;

   typedef struct {
      int out;
      bit carry;
      bit sat;
      bit zero;
   } res_t;

   logic         clk = 1'b0;
   logic         reset;
   logic         in_valid;
   logic [1:0]   op;
   logic [W-1:0] a, b, c;
   logic         acc_clr;
   logic         out_ready;

   logic [W-1:0] mon_a_w, mon_b_w, mon_c_w, mon_acc_w;
   logic [W-1:0] mon_a_s, mon_b_s, mon_c_s, mon_acc_s;
   logic [1:0]   occ_w, occ_s;

   int checks = 0;
   int errors = 0;

   // Model state
   txn_t q[$];
   int   acc_m[2];
   res_t exp_r[2];
   int   last_a, last_b, last_c;
   bit   in_fire, out_fire;
   logic [10:0] got_w[$];
   logic [10:0] got_s[$];

   always #5 clk = ~clk;

   alu_select_pipe_if #(.WIDTH(W)) if_w ();
   alu_select_pipe_if #(.WIDTH(W)) if_s ();

   assign if_w.in_valid  = in_valid;
   assign if_w.op        = op;
   assign if_w.a         = a;
   assign if_w.b         = b;
   assign if_w.c         = c;
   assign if_w.acc_clr   = acc_clr;
   assign if_w.out_ready = out_ready;
   assign if_s.in_valid  = in_valid;
   assign if_s.op        = op;
   assign if_s.a         = a;
   assign if_s.b         = b;
   assign if_s.c         = c;
   assign if_s.acc_clr   = acc_clr;
   assign if_s.out_ready = out_ready;

   alu_select_pipe #(.WIDTH(W), .SAT_EN(1'b0)) u_dut_w (
      .clk          (clk),
      .reset        (reset),
      .bus          (if_w),
      .s1_a_monitor (mon_a_w),
      .s1_b_monitor (mon_b_w),
      .s1_c_monitor (mon_c_w),
      .acc_monitor  (mon_acc_w),
      .occupancy    (occ_w)
   );

   alu_select_pipe #(.WIDTH(W), .SAT_EN(1'b1)) u_dut_s (
      .clk          (clk),
      .reset        (reset),
      .bus          (if_s),
      .s1_a_monitor (mon_a_s),
      .s1_b_monitor (mon_b_s),
      .s1_c_monitor (mon_c_s),
      .acc_monitor  (mon_acc_s),
      .occupancy    (occ_s)
   );

   task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic res_t compute(txn_t t, int acc, bit sat_en);
      res_t r;
      int   full;
      r.carry = 1'b0;
      case (t.op)
         1: begin full = t.a + t.b; r.carry = (full > TOP); end
         2: begin full = t.a - t.c; r.carry = (t.a < t.c); end
         3: begin full = acc + t.a; r.carry = (full > TOP); end
         default: full = t.a;
      endcase
      if (sat_en && r.carry) begin
         r.sat = 1'b1;
         r.out = (t.op == 2) ? 0 : TOP;
      end else begin
         r.sat = 1'b0;
         r.out = full & TOP;
      end
      r.zero = (r.out == 0);
      return r;
   endfunction

   task automatic drive(bit v, int o, int av, int bv, int cv);
      in_valid = v;
      op       = o[1:0];
      a        = av[W-1:0];
      b        = bv[W-1:0];
      c        = cv[W-1:0];
   endtask

   task automatic check_dut(string tag, int k, logic ov, logic [W-1:0] o,
                            logic cy, logic st, logic z, logic [W-1:0] ma,
                            logic [W-1:0] mb, logic [W-1:0] mc,
                            logic [W-1:0] macc, logic [1:0] occ);
      bit ev;
      ev = (q.size() > 0) && q[0].shown;
      check($sformatf("%s_out_valid", tag), ov, ev);
      check($sformatf("%s_occupancy", tag), occ, q.size());
      check($sformatf("%s_acc", tag), macc, acc_m[k]);
      check($sformatf("%s_s1_a", tag), ma, last_a);
      check($sformatf("%s_s1_b", tag), mb, last_b);
      check($sformatf("%s_s1_c", tag), mc, last_c);
      if (reset) begin
         check($sformatf("%s_rst_out", tag), {cy, st, z, o}, 0);
      end else if (ev) begin
         check($sformatf("%s_out", tag), o, exp_r[k].out);
         check($sformatf("%s_carry", tag), cy, exp_r[k].carry);
         check($sformatf("%s_sat", tag), st, exp_r[k].sat);
         check($sformatf("%s_zero", tag), z, exp_r[k].zero);
      end
   endtask

   // One clock: check in_ready before the edge, advance the model, check after.
   task automatic step();
      bit   exp_ready;
      bit   exp_valid;
      txn_t t;
      int   new_acc[2];
      res_t r;
      @(negedge clk);
      exp_ready = !reset && !((q.size() == 2) && !out_ready);
      exp_valid = (q.size() > 0) && q[0].shown;
      check("w_in_ready", if_w.in_ready, exp_ready);
      check("s_in_ready", if_s.in_ready, exp_ready);
      in_fire  = in_valid && exp_ready;
      out_fire = exp_valid && out_ready;
      if (if_w.out_valid && out_ready)
         got_w.push_back({if_w.out_carry, if_w.out_sat, if_w.out_zero, if_w.out});
      if (if_s.out_valid && out_ready)
         got_s.push_back({if_s.out_carry, if_s.out_sat, if_s.out_zero, if_s.out});
      @(posedge clk);
      #1;
      if (reset) begin
         q.delete();
         acc_m  = '{0, 0};
         last_a = 0;
         last_b = 0;
         last_c = 0;
      end else begin
         if (out_fire) void'(q.pop_front());
         for (int i = 0; i < q.size(); i++) begin
            t = q[i];
            t.age++;
            q[i] = t;
         end
         if (in_fire) begin
            t = '{op: int'(op), a: int'(a), b: int'(b), c: int'(c), age: 0, shown: 1'b0};
            q.push_back(t);
            last_a = int'(a);
            last_b = int'(b);
            last_c = int'(c);
         end
         new_acc = acc_m;
         if ((q.size() > 0) && (q[0].age >= 1) && !q[0].shown) begin
            t = q[0];
            t.shown = 1'b1;
            q[0] = t;
            for (int k = 0; k < 2; k++) begin
               r = compute(t, acc_m[k], k == 1);
               exp_r[k] = r;
               if (t.op == 3) new_acc[k] = r.out;
            end
         end
         if (acc_clr) new_acc = '{0, 0};
         acc_m = new_acc;
      end
      check_dut("w", 0, if_w.out_valid, if_w.out, if_w.out_carry, if_w.out_sat,
                if_w.out_zero, mon_a_w, mon_b_w, mon_c_w, mon_acc_w, occ_w);
      check_dut("s", 1, if_s.out_valid, if_s.out, if_s.out_carry, if_s.out_sat,
                if_s.out_zero, mon_a_s, mon_b_s, mon_c_s, mon_acc_s, occ_s);
   endtask

   initial begin
      int k;
      reset     = 1'b1;
      acc_clr   = 1'b0;
      out_ready = 1'b1;
      drive(1, 0, 55, 0, 0);

      // Reset held two cycles with a bundle offered
      step();
      step();

      // Back-to-back PASS / ADD / SUB, unstalled
      reset = 1'b0;
      got_w.delete();
      drive(1, 0, 10, 0, 0);  step();
      drive(1, 1, 10, 20, 0); step();
      drive(1, 2, 10, 0, 3);  step();
      drive(0, 0, 0, 0, 0);
      repeat (4) step();
      check("b2b_count", got_w.size(), 3);
      check("b2b_out0", got_w[0][7:0], 10);
      check("b2b_out1", got_w[1][7:0], 30);
      check("b2b_out2", got_w[2][7:0], 7);

      // Overflow / underflow, wrapping and saturating
      got_w.delete();
      got_s.delete();
      drive(1, 1, 200, 100, 0); step();
      drive(1, 2, 5, 0, 9);     step();
      drive(0, 0, 0, 0, 0);
      repeat (4) step();
      check("ovf_count_w", got_w.size(), 2);
      check("ovf_count_s", got_s.size(), 2);
      check("ovf_add_w", got_w[0], {3'b100, 8'd44});
      check("ovf_sub_w", got_w[1], {3'b100, 8'd252});
      check("ovf_add_s", got_s[0], {3'b110, 8'd255});
      check("ovf_sub_s", got_s[1], {3'b111, 8'd0});

      // Backpressure: four PASS bundles with the sink stalled for a while
      got_w.delete();
      out_ready = 1'b0;
      k = 0;
      for (int cyc = 0; cyc < 40 && !(k == 4 && q.size() == 0); cyc++) begin
         if (cyc == 6) out_ready = 1'b1;
         drive(k < 4, 0, k + 1, 0, 0);
         step();
         if (in_fire) k++;
         if (cyc == 5) begin
            check("bp_accepts", k, 2);
            check("bp_occupancy", occ_w, 2);
            check("bp_in_ready", if_w.in_ready, 0);
         end
      end
      drive(0, 0, 0, 0, 0);
      check("bp_all_accepted", k, 4);
      check("bp_count", got_w.size(), 4);
      for (int i = 0; i < 4; i++) check($sformatf("bp_order%0d", i), got_w[i][7:0], i + 1);

      // Accumulate six times 50
      acc_clr = 1'b1; step(); acc_clr = 1'b0;
      got_w.delete();
      got_s.delete();
      for (int i = 0; i < 6; i++) begin
         drive(1, 3, 50, 0, 0);
         step();
      end
      drive(0, 0, 0, 0, 0);
      repeat (3) step();
      check("acc_count", got_w.size(), 6);
      for (int i = 0; i < 5; i++) check($sformatf("acc_w%0d", i), got_w[i][7:0], 50 * (i + 1));
      check("acc_w5", got_w[5], {3'b100, 8'd44});
      check("acc_s5", got_s[5], {3'b110, 8'd255});

      // acc_clr on the cycle the third ACC advances
      acc_clr = 1'b1; step(); acc_clr = 1'b0;
      got_w.delete();
      for (int i = 0; i < 4; i++) begin
         drive(1, 3, 50, 0, 0);
         acc_clr = (i == 3);
         step();
      end
      acc_clr = 1'b0;
      check("clr_acc_mon", mon_acc_w, 0);
      drive(0, 0, 0, 0, 0);
      repeat (3) step();
      check("clr_count", got_w.size(), 4);
      check("clr_out2", got_w[2][7:0], 150);
      check("clr_out3", got_w[3][7:0], 50);

      // Reset with two bundles in flight
      out_ready = 1'b0;
      drive(1, 0, 8, 0, 0); step();
      drive(1, 0, 9, 0, 0); step();
      check("mid_occ_before", occ_w, 2);
      drive(0, 0, 0, 0, 0);
      reset = 1'b1; step(); reset = 1'b0;
      check("mid_out_valid", if_w.out_valid, 0);
      check("mid_occ", occ_w, 0);
      out_ready = 1'b1;
      drive(1, 0, 7, 0, 0); step();
      drive(0, 0, 0, 0, 0); step();
      check("mid_new_valid", if_w.out_valid, 1);
      check("mid_new_out", if_w.out, 7);
      step();

      // Randomized traffic
      for (int i = 0; i < 400; i++) begin
         drive($urandom_range(0, 3) != 0, $urandom_range(0, 3), $urandom_range(0, TOP),
               $urandom_range(0, TOP), $urandom_range(0, TOP));
         out_ready = ($urandom_range(0, 9) < 7);
         acc_clr   = ($urandom_range(0, 19) == 0);
         reset     = ($urandom_range(0, 99) == 0);
         step();
      end
      reset     = 1'b0;
      acc_clr   = 1'b0;
      out_ready = 1'b1;
      drive(0, 0, 0, 0, 0);
      repeat (4) step();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
